// File: rtl/vending_pkg.sv
// Shared defaults, state type and coin arithmetic helper
// for the vending credit/change controller.
package vending_pkg;

  localparam int DEF_NUM_COINS = 3;
  localparam int DEF_NUM_ITEMS = 4;
  localparam int DEF_BAL_W     = 16;

  localparam logic [47:0] DEF_COIN_VALUES =
    {16'd1000, 16'd500, 16'd100};
  localparam logic [63:0] DEF_ITEM_PRICES =
    {16'd2000, 16'd1000, 16'd500, 16'd400};
  localparam int unsigned DEF_WAIT_CYCLES = 100;

  // Fixed-size slots so one helper serves every instance.
  localparam int MAX_N = 16;
  localparam int VAL_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    RETURN
  } state_t;

  function automatic logic [VAL_W-1:0] coin_sum(
    input logic [MAX_N-1:0]       mask,
    input logic [MAX_N*VAL_W-1:0] vals
  );
    logic [VAL_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_N; i++)
      if (mask[i])
        s = s + vals[i*VAL_W +: VAL_W];
    return s;
  endfunction

endpackage

// File: rtl/vending_credit_ctrl_change_picker.sv
// Picks the largest coin not exceeding the balance.
// Ports: balance in; one-hot coin and its value out (0 if none fits).
module change_picker
  import vending_pkg::*;
#(
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int BAL_W     = DEF_BAL_W,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALUES =
    DEF_COIN_VALUES
) (
  input  logic [BAL_W-1:0]     balance,
  output logic [NUM_COINS-1:0] coin,
  output logic [BAL_W-1:0]     value
);

  // Denominations ascend, so the last fit is the largest.
  always_comb begin
    coin  = '0;
    value = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (balance >= COIN_VALUES[i*BAL_W +: BAL_W]) begin
        coin    = '0;
        coin[i] = 1'b1;
        value   = COIN_VALUES[i*BAL_W +: BAL_W];
      end
    end
  end

endmodule

// File: rtl/vending_credit_ctrl.sv
// Credit accumulation, vending, timeout and greedy change payout.
// Ports: coin/select/return requests in; vend, change, reject, balance, timer, busy out.
module vending_credit_ctrl
  import vending_pkg::*;
#(
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int BAL_W     = DEF_BAL_W,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALUES =
    DEF_COIN_VALUES,
  parameter logic [NUM_ITEMS*BAL_W-1:0] ITEM_PRICES =
    DEF_ITEM_PRICES,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned MAX_BALANCE = 2**BAL_W - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_COINS-1:0] i_input_coin,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic                 i_trigger_return,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [NUM_COINS-1:0] o_return_coin,
  output logic                 o_coin_reject,
  output logic [BAL_W-1:0]     o_balance,
  output logic [31:0]          o_wait_time,
  output logic                 o_busy
);

  function automatic logic [NUM_ITEMS-1:0] free_items();
    logic [NUM_ITEMS-1:0] f;
    for (int k = 0; k < NUM_ITEMS; k++)
      f[k] = (ITEM_PRICES[k*BAL_W +: BAL_W] == '0);
    return f;
  endfunction

  localparam logic [NUM_ITEMS-1:0] FREE_ITEMS = free_items();
  localparam logic [BAL_W-1:0] MIN_COIN = COIN_VALUES[BAL_W-1:0];

  state_t               state_q, state_d;
  logic [BAL_W-1:0]     bal_q, bal_d;
  logic [31:0]          wait_q, wait_d;
  logic [NUM_ITEMS-1:0] item_q, item_d;
  logic [NUM_COINS-1:0] coin_q, coin_d;
  logic                 rej_q, rej_d;
  logic                 busy_q, busy_d;
  logic [NUM_ITEMS-1:0] avail_q, avail_d;

  logic [MAX_N-1:0]       mask;
  logic [MAX_N*VAL_W-1:0] vals;
  logic [VAL_W-1:0]       sum;
  logic [VAL_W:0]         tot;
  logic                   coin_any, coin_ok;
  logic [BAL_W-1:0]       bal1;
  logic [NUM_ITEMS-1:0]   sel_oh;
  logic [BAL_W-1:0]       sel_price;
  logic                   vend_ok;
  logic [NUM_COINS-1:0]   pick_coin;
  logic [BAL_W-1:0]       pick_val;

  change_picker #(
    .NUM_COINS  (NUM_COINS),
    .BAL_W      (BAL_W),
    .COIN_VALUES(COIN_VALUES)
  ) u_pick (
    .balance(bal_q),
    .coin   (pick_coin),
    .value  (pick_val)
  );

  always_comb begin
    mask = '0;
    mask[NUM_COINS-1:0] = i_input_coin;
    vals = '0;
    for (int i = 0; i < NUM_COINS; i++)
      vals[i*VAL_W +: VAL_W] =
        VAL_W'(COIN_VALUES[i*BAL_W +: BAL_W]);
    sum      = coin_sum(mask, vals);
    tot      = (VAL_W+1)'(bal_q) + (VAL_W+1)'(sum);
    coin_any = |i_input_coin;
    coin_ok  = coin_any &&
               (tot <= (VAL_W+1)'(MAX_BALANCE));
    bal1     = coin_ok ? tot[BAL_W-1:0] : bal_q;
  end

  // Lowest-index selection wins; walk downward so it lands last.
  always_comb begin
    sel_oh    = '0;
    sel_price = '0;
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (i_select_item[k]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        sel_price = ITEM_PRICES[k*BAL_W +: BAL_W];
      end
    end
    vend_ok = (|i_select_item) && (bal1 >= sel_price);
  end

  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    wait_d  = wait_q;
    item_d  = '0;
    coin_d  = '0;
    rej_d   = 1'b0;
    unique case (state_q)
      RETURN: begin
        if (bal_q < MIN_COIN) begin
          bal_d   = '0;
          state_d = IDLE;
          wait_d  = WAIT_CYCLES;
        end else begin
          coin_d = pick_coin;
          bal_d  = bal_q - pick_val;
          if (bal_d == '0) begin
            state_d = IDLE;
            wait_d  = WAIT_CYCLES;
          end
        end
      end
      default: begin
        if (state_q == CREDIT && i_trigger_return) begin
          state_d = RETURN;
        end else begin
          rej_d  = coin_any && !coin_ok;
          bal_d  = vend_ok ? bal1 - sel_price : bal1;
          item_d = vend_ok ? sel_oh : '0;
          if (bal_d == '0) begin
            state_d = IDLE;
            wait_d  = WAIT_CYCLES;
          end else if (coin_ok || vend_ok ||
                       state_q == IDLE) begin
            state_d = CREDIT;
            wait_d  = WAIT_CYCLES;
          end else begin
            wait_d  = wait_q - 32'd1;
            state_d = (wait_q == 32'd1) ? RETURN : CREDIT;
          end
        end
      end
    endcase
    busy_d = (state_d == RETURN);
    for (int k = 0; k < NUM_ITEMS; k++)
      avail_d[k] = !busy_d &&
        (bal_d >= ITEM_PRICES[k*BAL_W +: BAL_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bal_q   <= '0;
      wait_q  <= WAIT_CYCLES;
      item_q  <= '0;
      coin_q  <= '0;
      rej_q   <= 1'b0;
      busy_q  <= 1'b0;
      avail_q <= FREE_ITEMS;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      wait_q  <= wait_d;
      item_q  <= item_d;
      coin_q  <= coin_d;
      rej_q   <= rej_d;
      busy_q  <= busy_d;
      avail_q <= avail_d;
    end
  end

  assign o_available_item = avail_q;
  assign o_output_item    = item_q;
  assign o_return_coin    = coin_q;
  assign o_coin_reject    = rej_q;
  assign o_balance        = bal_q;
  assign o_wait_time      = wait_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Directed and random stimulus for vending_credit_ctrl,
// compared against a payout-queue model of the credit rules.
module tb_vending_credit_ctrl;

  localparam int NC   = 3;
  localparam int NI   = 4;
  localparam int W    = 16;
  localparam int WAIT = 100;
  localparam int MAXB = 2000;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] i_input_coin;
  logic [NI-1:0] i_select_item;
  logic          i_trigger_return;
  logic [NI-1:0] o_available_item;
  logic [NI-1:0] o_output_item;
  logic [NC-1:0] o_return_coin;
  logic          o_coin_reject;
  logic [W-1:0]  o_balance;
  logic [31:0]   o_wait_time;
  logic          o_busy;

  vending_credit_ctrl #(
    .MAX_BALANCE(MAXB)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_input_coin    (i_input_coin),
    .i_select_item   (i_select_item),
    .i_trigger_return(i_trigger_return),
    .o_available_item(o_available_item),
    .o_output_item   (o_output_item),
    .o_return_coin   (o_return_coin),
    .o_coin_reject   (o_coin_reject),
    .o_balance       (o_balance),
    .o_wait_time     (o_wait_time),
    .o_busy          (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cv [NC] = '{100, 500, 1000};
  int pr [NI] = '{400, 500, 1000, 2000};

  int checks   = 0;
  int failures = 0;

  int m_bal, m_tmr;
  bit m_pay;
  int m_q[$];
  logic [NI-1:0] e_item, e_avail;
  logic [NC-1:0] e_coin;
  logic          e_rej;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_queue();
    int b;
    b = m_bal;
    m_q.delete();
    while (b >= cv[0]) begin
      for (int i = NC - 1; i >= 0; i--) begin
        if (cv[i] <= b) begin
          m_q.push_back(i);
          b -= cv[i];
          break;
        end
      end
    end
    if (b > 0) m_q.push_back(-1);
    m_pay = 1;
  endtask

  task automatic model_reset();
    m_bal = 0; m_tmr = WAIT; m_pay = 0;
    m_q.delete();
    e_item = '0; e_coin = '0; e_rej = 1'b0;
    e_avail = '0;
  endtask

  task automatic model_step(input logic [NC-1:0] c,
                            input logic [NI-1:0] s,
                            input logic t);
    int sum, k, c_idx;
    bit prog, was_idle;
    e_item = '0; e_coin = '0; e_rej = 1'b0;
    if (m_pay) begin
      c_idx = m_q.pop_front();
      if (c_idx >= 0) begin
        e_coin[c_idx] = 1'b1;
        m_bal -= cv[c_idx];
      end else begin
        m_bal = 0;
      end
      if (m_q.size() == 0) begin
        m_pay = 0;
        m_bal = 0;
        m_tmr = WAIT;
      end
    end else if (m_bal > 0 && t) begin
      fill_queue();
    end else begin
      was_idle = (m_bal == 0);
      prog = 0;
      sum = 0;
      for (int i = 0; i < NC; i++) if (c[i]) sum += cv[i];
      if (sum > 0) begin
        if (m_bal + sum > MAXB) e_rej = 1'b1;
        else begin m_bal += sum; prog = 1; end
      end
      k = -1;
      for (int i = NI - 1; i >= 0; i--) if (s[i]) k = i;
      if (k >= 0 && m_bal >= pr[k]) begin
        m_bal -= pr[k];
        e_item[k] = 1'b1;
        prog = 1;
      end
      if (m_bal == 0 || prog || was_idle) m_tmr = WAIT;
      else begin
        m_tmr--;
        if (m_tmr == 0) fill_queue();
      end
    end
    for (int i = 0; i < NI; i++)
      e_avail[i] = !m_pay && (m_bal >= pr[i]);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bal"},   32'(o_balance), m_bal);
    chk({tag, ".wait"},  o_wait_time, m_tmr);
    chk({tag, ".item"},  32'(o_output_item), 32'(e_item));
    chk({tag, ".coin"},  32'(o_return_coin), 32'(e_coin));
    chk({tag, ".rej"},   32'(o_coin_reject), 32'(e_rej));
    chk({tag, ".busy"},  32'(o_busy), 32'(m_pay));
    chk({tag, ".avail"}, 32'(o_available_item), 32'(e_avail));
  endtask

  task automatic step(input logic [NC-1:0] c,
                      input logic [NI-1:0] s,
                      input logic t,
                      input string tag);
    i_input_coin     = c;
    i_select_item    = s;
    i_trigger_return = t;
    @(posedge clk);
    #1;
    model_step(c, s, t);
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b1;
    i_input_coin = '0;
    i_select_item = '0;
    i_trigger_return = 1'b0;
    #2 reset_n = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Two coins on separate cycles, then vend item 1
    step(3'b100, 4'b0000, 1'b0, "c1000");
    step(3'b000, 4'b0000, 1'b0, "idle1");
    step(3'b010, 4'b0000, 1'b0, "c500");
    step(3'b000, 4'b0010, 1'b0, "vend1");
    chk("vend1.item_lit", 32'(o_output_item), 32'h2);

    // Build 1600 and trigger return
    step(3'b010, 4'b0000, 1'b0, "to1600a");
    step(3'b001, 4'b0000, 1'b0, "to1600b");
    chk("bal1600", 32'(o_balance), 32'd1600);
    step(3'b000, 4'b0000, 1'b1, "trig");
    step(3'b101, 4'b0001, 1'b1, "pay0");
    chk("pay0.lit", 32'(o_return_coin), 32'h4);
    step(3'b000, 4'b0000, 1'b0, "pay1");
    step(3'b000, 4'b0000, 1'b0, "pay2");
    chk("pay2.lit", 32'(o_return_coin), 32'h1);
    step(3'b000, 4'b0000, 1'b1, "idle_trig");

    // Timeout path
    step(3'b010, 4'b0000, 1'b0, "t500");
    for (int n = 0; n < WAIT; n++)
      step(3'b000, 4'b0000, 1'b0, "tick");
    chk("timeout.wait", o_wait_time, 32'd0);
    step(3'b000, 4'b0000, 1'b0, "tpay");
    chk("tpay.lit", 32'(o_return_coin), 32'h2);

    // Unaffordable lowest-index select, then coin+vend same cycle
    step(3'b001, 4'b0000, 1'b0, "b100");
    step(3'b001, 4'b0000, 1'b0, "b200");
    step(3'b001, 4'b0000, 1'b0, "b300");
    step(3'b000, 4'b1001, 1'b0, "novend");
    step(3'b001, 4'b0011, 1'b0, "cvend");
    chk("cvend.lit", 32'(o_output_item), 32'h1);

    // Overflow reject at MAX_BALANCE
    step(3'b100, 4'b0000, 1'b0, "r1000");
    step(3'b010, 4'b0000, 1'b0, "r500");
    step(3'b001, 4'b0000, 1'b0, "r100");
    step(3'b101, 4'b0000, 1'b0, "reject");
    chk("reject.lit", 32'(o_coin_reject), 32'h1);
    step(3'b000, 4'b0000, 1'b0, "rej_clr");

    // Reset during payout
    step(3'b000, 4'b0000, 1'b1, "trig2");
    step(3'b000, 4'b0000, 1'b0, "pay2_0");
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      check_all("held_reset");
    end
    reset_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [NC-1:0] c;
      logic [NI-1:0] s;
      logic t;
      c = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
      s = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
      t = ($urandom_range(0, 24) == 0);
      step(c, s, t, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
